// File: rtl/nmea_pkg.sv
// Shared types and helpers for the NMEA sentence controller.
// ACCEPT_LOWER_HEX_EN: when defined, 'a'-'f' are also accepted as checksum digits.
package nmea_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SKIP,
    S_CAP,
    S_TAIL,
    S_CSH,
    S_CSL
  } nmea_state_e;

  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] COMMA  = 8'h2C;
  localparam logic [7:0] STAR   = 8'h2A;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

  // 'A'/'a' have low nibble 1, so +9 maps them onto 10.
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.vld = 1'b0;
    h.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      h.vld = 1'b1;
      h.nib = c[3:0];
    end else if (c >= 8'h41 && c <= 8'h46) begin
      h.vld = 1'b1;
      h.nib = c[3:0] + 4'd9;
    end
`ifdef ACCEPT_LOWER_HEX_EN
    else if (c >= 8'h61 && c <= 8'h66) begin
      h.vld = 1'b1;
      h.nib = c[3:0] + 4'd9;
    end
`endif
    return h;
  endfunction

endpackage

// File: rtl/nmea_field_buf.sv
// One-byte pending register for the captured field: delays each byte until the
// next one (or the terminator) shows whether it is the last, and saturates the length.
module nmea_field_buf #(
  parameter int MAX_FIELD_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       term,
  input  logic [7:0] din,
  output logic [7:0] field_data,
  output logic       field_valid,
  output logic       field_last,
  output logic       field_trunc
);

  localparam int CW = $clog2(MAX_FIELD_LEN + 1);

  logic [7:0]    pend;
  logic          pend_vld;
  logic [CW-1:0] cnt;
  logic          room;

  assign room = cnt < CW'(MAX_FIELD_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      pend_vld    <= 1'b0;
      cnt         <= '0;
      field_data  <= '0;
      field_valid <= 1'b0;
      field_last  <= 1'b0;
      field_trunc <= 1'b0;
    end else begin
      field_valid <= 1'b0;
      field_last  <= 1'b0;
      if (clr) begin
        pend_vld    <= 1'b0;
        cnt         <= '0;
        field_trunc <= 1'b0;
      end else if (push) begin
        if (pend_vld) begin
          if (room) begin
            field_data  <= pend;
            field_valid <= 1'b1;
            cnt         <= cnt + CW'(1);
          end else begin
            field_trunc <= 1'b1;
          end
        end
        pend     <= din;
        pend_vld <= 1'b1;
      end else if (term) begin
        // A pending byte past the limit is dropped, so the field ends without last.
        if (pend_vld) begin
          if (room) begin
            field_data  <= pend;
            field_valid <= 1'b1;
            field_last  <= 1'b1;
          end else begin
            field_trunc <= 1'b1;
          end
        end
        pend_vld <= 1'b0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: rtl/nmea_sentence_ctrl.sv
// NMEA-0183 sentence sequencer: header match, field capture, XOR checksum check.
// ACCEPT_LOWER_HEX_EN (see nmea_pkg) widens the accepted checksum digits.
module nmea_sentence_ctrl
  import nmea_pkg::*;
#(
  parameter int                    HEADER_LEN    = 5,
  parameter logic [8*HEADER_LEN-1:0] HEADER      = "GPGGA",
  parameter int                    MAX_FIELD_LEN = 16,
  parameter int                    FSEL_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic [FSEL_W-1:0] field_sel,
  output logic [7:0]        field_data,
  output logic              field_valid,
  output logic              field_last,
  output logic              field_trunc,
  output logic              sentence_done,
  output logic              checksum_ok,
  output logic              frame_err,
  output logic              busy
);

  localparam int IW = $clog2(HEADER_LEN + 1);

  nmea_state_e       state;
  logic [7:0]        acc;
  logic [FSEL_W-1:0] sel_q;
  logic [FSEL_W-1:0] field_cnt;
  logic [FSEL_W-1:0] fnext;
  logic [IW-1:0]     hdr_idx;
  logic [3:0]        ck_hi;
  logic [7:0]        hdr_ch;
  hex_t              hx;
  logic              is_dollar, is_comma, is_star;
  logic              buf_clr, buf_push, buf_term;

  assign is_dollar = din == DOLLAR;
  assign is_comma  = din == COMMA;
  assign is_star   = din == STAR;
  assign hx        = hex_decode(din);
  assign busy      = state != S_IDLE;
  // Saturate so a long sentence cannot wrap back onto the selected index.
  assign fnext     = (&field_cnt) ? field_cnt : field_cnt + FSEL_W'(1);

  always_comb begin
    hdr_ch = '0;
    for (int i = 0; i < HEADER_LEN; i++)
      if (hdr_idx == IW'(i)) hdr_ch = HEADER[8*(HEADER_LEN-1-i) +: 8];
  end

  assign buf_clr  = din_valid && is_dollar;
  assign buf_push = din_valid && state == S_CAP && !is_dollar && !is_comma && !is_star;
  assign buf_term = din_valid && state == S_CAP && (is_comma || is_star);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      acc           <= '0;
      sel_q         <= '0;
      field_cnt     <= '0;
      hdr_idx       <= '0;
      ck_hi         <= '0;
      sentence_done <= 1'b0;
      checksum_ok   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sentence_done <= 1'b0;
      frame_err     <= 1'b0;
      if (din_valid) begin
        if (is_dollar) begin
          // '$' always (re)starts a sentence; mid-sentence it is also an abort.
          if (state != S_IDLE) frame_err <= 1'b1;
          state   <= S_HDR;
          acc     <= '0;
          sel_q   <= field_sel;
          hdr_idx <= '0;
        end else begin
          case (state)
            S_HDR: begin
              acc <= acc ^ din;
              if (hdr_idx == IW'(HEADER_LEN)) begin
                if (is_comma) begin
                  field_cnt <= FSEL_W'(1);
                  state     <= (sel_q == FSEL_W'(1)) ? S_CAP : S_SKIP;
                end else begin
                  state <= S_IDLE;
                end
              end else if (din == hdr_ch) begin
                hdr_idx <= hdr_idx + IW'(1);
              end else begin
                state <= S_IDLE;
              end
            end
            S_SKIP: begin
              if (is_star) begin
                state <= S_CSH;
              end else begin
                acc <= acc ^ din;
                if (is_comma) begin
                  field_cnt <= fnext;
                  if (fnext == sel_q) state <= S_CAP;
                end
              end
            end
            S_CAP: begin
              if (is_star) begin
                state <= S_CSH;
              end else begin
                acc <= acc ^ din;
                if (is_comma) state <= S_TAIL;
              end
            end
            S_TAIL: begin
              if (is_star) state <= S_CSH;
              else         acc   <= acc ^ din;
            end
            S_CSH: begin
              if (hx.vld) begin
                ck_hi <= hx.nib;
                state <= S_CSL;
              end else begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
              end
            end
            S_CSL: begin
              if (hx.vld) begin
                sentence_done <= 1'b1;
                checksum_ok   <= {ck_hi, hx.nib} == acc;
              end else begin
                frame_err <= 1'b1;
              end
              state <= S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  nmea_field_buf #(
    .MAX_FIELD_LEN(MAX_FIELD_LEN)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (buf_clr),
    .push       (buf_push),
    .term       (buf_term),
    .din        (din),
    .field_data (field_data),
    .field_valid(field_valid),
    .field_last (field_last),
    .field_trunc(field_trunc)
  );

endmodule

// File: tb/tb_nmea_sentence_ctrl.sv
// Scoreboard bench: a string-level sentence model predicts field bytes, done and abort pulses.
module tb_nmea_sentence_ctrl;

  localparam int HL   = 5;
  localparam int MAXF = 4;
  localparam int FSW  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     din = '0;
  logic           din_valid = 1'b0;
  logic [FSW-1:0] field_sel = '0;
  logic [7:0]     field_data;
  logic           field_valid, field_last, field_trunc;
  logic           sentence_done, checksum_ok, frame_err, busy;

  always #5 clk = ~clk;

  nmea_sentence_ctrl #(
    .HEADER_LEN(HL), .HEADER("GPGGA"), .MAX_FIELD_LEN(MAXF), .FSEL_W(FSW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .field_sel(field_sel),
    .field_data(field_data), .field_valid(field_valid), .field_last(field_last),
    .field_trunc(field_trunc), .sentence_done(sentence_done), .checksum_ok(checksum_ok),
    .frame_err(frame_err), .busy(busy)
  );

  typedef struct { logic [7:0] d; logic l; } fexp_t;
  typedef struct { logic ok; logic tr; } dexp_t;

  fexp_t          fq[$];
  dexp_t          dq[$];
  int             eq_n = 0;
  int             tests = 0, fails = 0;
  logic [7:0]     sb[$];
  logic [FSW-1:0] ss[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef ACCEPT_LOWER_HEX_EN
    if (c >= "a" && c <= "f") return int'(c) - 87;
`endif
    return -1;
  endfunction

  // One sentence = the bytes after a '$' up to the next '$' (has_next) or end of stream.
  function automatic void eval_seg(input logic [7:0] seg[$], input int sel, input bit has_next);
    string      h = "GPGGA";
    int         n = seg.size();
    int         star = -1, nf = 1, ne, v1, v2, endb;
    logic [7:0] fb[$];
    logic [7:0] x = 8'h00;
    logic [7:0] ec;
    bit         term, tr = 1'b0;
    for (int k = 0; k <= HL; k++) begin
      ec = (k < HL) ? h[k] : 8'h2C;
      if (k >= n) begin if (has_next) eq_n++; return; end
      if (seg[k] != ec) return;
    end
    for (int k = HL + 1; k < n; k++)
      if (seg[k] == 8'h2A) begin star = k; break; end
    endb = (star >= 0) ? star : n;
    for (int k = HL + 1; k < endb; k++) begin
      if (seg[k] == 8'h2C) nf++;
      else if (nf == sel) fb.push_back(seg[k]);
    end
    if (sel >= 1 && sel <= nf) begin
      term = (sel < nf) || (star >= 0);
      ne = term ? fb.size() : ((fb.size() > 0) ? fb.size() - 1 : 0);
      if (ne > MAXF) ne = MAXF;
      for (int k = 0; k < ne; k++)
        fq.push_back('{fb[k], term && fb.size() <= MAXF && k == ne - 1});
      tr = term && fb.size() > MAXF;
    end
    if (star < 0) begin if (has_next) eq_n++; return; end
    for (int k = 0; k < star; k++) x ^= seg[k];
    if (star + 1 >= n) begin if (has_next) eq_n++; return; end
    v1 = hexv(seg[star+1]);
    if (v1 < 0) begin eq_n++; return; end
    if (star + 2 >= n) begin if (has_next) eq_n++; return; end
    v2 = hexv(seg[star+2]);
    if (v2 < 0) begin eq_n++; return; end
    dq.push_back('{(v1 * 16 + v2) == int'(x), tr});
  endfunction

  function automatic void model();
    logic [7:0] seg[$];
    int i = 0, j, sel;
    while (i < sb.size()) begin
      if (sb[i] != 8'h24) begin i++; continue; end
      sel = int'(ss[i]);
      seg.delete();
      j = i + 1;
      while (j < sb.size() && sb[j] != 8'h24) begin seg.push_back(sb[j]); j++; end
      eval_seg(seg, sel, j < sb.size());
      i = j;
    end
  endfunction

  task automatic add_str(input string s, input int sel);
    for (int i = 0; i < s.len(); i++) begin
      sb.push_back(s[i]);
      ss.push_back(FSW'(sel));
    end
  endtask

  function automatic string ck_str(input string body, input bit bad, input bit lower);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < body.len(); i++) x ^= body[i];
    if (bad) x ^= 8'h01;
    return lower ? $sformatf("*%02x\r\n", x) : $sformatf("*%02X\r\n", x);
  endfunction

  task automatic add_sentence(input string body, input int sel, input bit bad, input bit lower);
    add_str({"$", body, ck_str(body, bad, lower)}, sel);
  endtask

  task automatic send(input logic [7:0] b, input logic [FSW-1:0] s);
    din = b; field_sel = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic run_batch();
    model();
    for (int i = 0; i < sb.size(); i++) send(sb[i], ss[i]);
    sb.delete(); ss.delete();
    repeat (4) @(posedge clk);
    #1;
    check("field_queue_drain", fq.size(), 0);
    check("done_queue_drain", dq.size(), 0);
    check("err_count_drain", eq_n, 0);
    fq.delete(); dq.delete(); eq_n = 0;
  endtask

  task automatic gen_rand();
    string body = "GPGGA", full, chars = "0123456789ABCDEF.NSEW";
    int sel = $urandom_range(0, 6), nf = $urandom_range(1, 5), mode = $urandom_range(0, 9);
    if ($urandom_range(0, 7) == 0) body[$urandom_range(0, 4)] = "X";
    for (int f = 0; f < nf; f++) begin
      body = {body, ","};
      for (int c = $urandom_range(0, 7); c > 0; c--)
        body = {body, $sformatf("%c", chars[$urandom_range(0, chars.len() - 1)])};
    end
    case (mode)
      1:       full = {"$", body, ck_str(body, 1'b1, 1'b0)};
      2:       full = {"$", body, ck_str(body, 1'b0, 1'b1)};
      3:       full = {"$", body, ($urandom_range(0, 1) != 0) ? "*G1\r\n" : "*1z\r\n"};
      default: full = {"$", body, ck_str(body, 1'b0, 1'b0)};
    endcase
    if (mode == 0) full = full.substr(0, $urandom_range(0, full.len() - 2));
    add_str(full, sel);
  endtask

  always @(negedge clk) begin
    fexp_t fe;
    dexp_t de;
    if (!rst) begin
      if (field_valid) begin
        if (fq.size() == 0) begin
          tests++; fails++;
          $display("FAIL field_unexpected: got %02h expected none", field_data);
        end else begin
          fe = fq.pop_front();
          check("field_data", field_data, fe.d);
          check("field_last", field_last, fe.l);
        end
      end
      if (sentence_done) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: got sentence_done expected none");
        end else begin
          de = dq.pop_front();
          check("checksum_ok", checksum_ok, de.ok);
          check("field_trunc", field_trunc, de.tr);
        end
      end
      if (frame_err) begin
        tests++;
        if (eq_n == 0) begin
          fails++;
          $display("FAIL frame_err_unexpected: got pulse expected none");
        end else eq_n--;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_field_valid", field_valid, 0);
    check("rst_field_last", field_last, 0);
    check("rst_field_trunc", field_trunc, 0);
    check("rst_sentence_done", sentence_done, 0);
    check("rst_checksum_ok", checksum_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_field_data", field_data, 0);

    // Reset mid-sentence: pending '1' must vanish with no pulses.
    @(posedge clk); #1;
    add_str("$GPGGA,1", 1);
    run_batch();
    check("busy_mid_sentence", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("busy_after_rst", busy, 0);

    add_sentence("GPGGA,1", 1, 1'b0, 1'b0);
    add_sentence("GPGGA,12,AB", 2, 1'b0, 1'b0);
    add_sentence("GPGGA,1", 1, 1'b1, 1'b0);
    add_str("$GPGGA,12", 1);
    add_sentence("GPGGA,1", 1, 1'b0, 1'b0);
    add_sentence("GPGGA,ABCDEF", 1, 1'b0, 1'b0);
    add_sentence("GPGGA,ABCD,X", 1, 1'b0, 1'b0);
    add_sentence("GPGGA,X,ABCDE", 2, 1'b0, 1'b0);
    add_sentence("GPGGA,,X", 1, 1'b0, 1'b0);
    add_sentence("GPGGA,AB,CD", 0, 1'b0, 1'b0);
    add_sentence("GPGGA,AB,CD", 5, 1'b0, 1'b0);
    add_sentence("GPGGA,AB", 1, 1'b0, 1'b1);
    add_str("\r\n$GPRMC,1*00\r\n", 1);
    run_batch();
    check("busy_after_bad_header", busy, 0);

    for (int b = 0; b < 25; b++) begin
      for (int s = 0; s < 8; s++) gen_rand();
      add_sentence("GPGGA,12,34", 2, 1'b0, 1'b0);
      run_batch();
    end
    check("busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
